montgomery_exp_ctrl: RTL

Initiator for the montgomery multiplier's start/done handshake. It computes a full modular exponentiation, result = x^e mod M, using left-to-right square-and-multiply. It drives one external montgomery instance (operands a, b, m; start pulse) and consumes that instance's result and done. It sits above the multiplier in the RSA datapath and owns operand sequencing, including the Montgomery-domain entry and exit.

---
 rtl/montgomery_pkg.sv | 22 ++
 rtl/exp_bit_scanner.sv | 39 +++
 rtl/montgomery_exp_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/montgomery_pkg.sv
// Shared types and defaults for the Montgomery exponentiation controller.
// Covers the FSM state encoding and the multiplier operation selector.
package montgomery_pkg;

  localparam int unsigned DwDefault = 512;
  localparam int unsigned EwDefault = 512;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StFinish
  } state_e;

  typedef enum logic [1:0] {
    OpEnter,
    OpSquare,
    OpMultiply,
    OpExit
  } op_e;

endpackage

// File: rtl/exp_bit_scanner.sv
// MSB-first exponent scanner: holds the shifting exponent and the count of bits left.
// Exposes the current bit and a flag that marks the final bit.
module exp_bit_scanner
  import montgomery_pkg::*;
#(
  parameter int unsigned EW = EwDefault
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [EW-1:0] load_val,
  input  logic          shift,
  output logic          cur_bit,
  output logic          last_bit
);

  localparam int unsigned CntW = $clog2(EW + 1);

  logic [EW-1:0]   e_sh_q;
  logic [CntW-1:0] bit_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      e_sh_q    <= '0;
      bit_cnt_q <= '0;
    end else if (load) begin
      e_sh_q    <= load_val;
      bit_cnt_q <= CntW'(EW);
    end else if (shift) begin
      e_sh_q    <= e_sh_q << 1;
      bit_cnt_q <= bit_cnt_q - CntW'(1);
    end
  end

  assign cur_bit  = e_sh_q[EW-1];
  // A shift while this is set leaves no bits to scan.
  assign last_bit = (bit_cnt_q == CntW'(1));

endmodule

// File: rtl/montgomery_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one external Montgomery multiplier.
// Operands enter the Montgomery domain via R^2 and leave it via a final multiply by 1.
module montgomery_exp_ctrl
  import montgomery_pkg::*;
#(
  parameter int unsigned DW = DwDefault,
  parameter int unsigned EW = EwDefault
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] in_x,
  input  logic [EW-1:0] in_e,
  input  logic [DW-1:0] in_m,
  input  logic [DW-1:0] in_r,
  input  logic [DW-1:0] in_r2,
  output logic [DW-1:0] result,
  output logic          done,
  output logic          busy,
  output logic          mm_start,
  output logic [DW-1:0] mm_a,
  output logic [DW-1:0] mm_b,
  output logic [DW-1:0] mm_m,
  input  logic [DW-1:0] mm_result,
  input  logic          mm_done
);

  state_e state_q, state_d;
  op_e    op_q, op_d;

  logic [DW-1:0] xm_q, xm_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] m_q, m_d;
  logic [DW-1:0] result_q, result_d;
  logic [DW-1:0] mm_a_q, mm_a_d;
  logic [DW-1:0] mm_b_q, mm_b_d;
  logic [DW-1:0] sel_a, sel_b;

  logic scan_load, scan_shift, cur_bit, last_bit;

  exp_bit_scanner #(
    .EW (EW)
  ) u_scanner (
    .clk      (clk),
    .reset    (reset),
    .load     (scan_load),
    .load_val (in_e),
    .shift    (scan_shift),
    .cur_bit  (cur_bit),
    .last_bit (last_bit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StIssue;
      StIssue:  state_d = StWait;
      StWait:   if (mm_done) state_d = (op_q == OpExit) ? StFinish : StIssue;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    mm_start = (state_q == StIssue);
    done     = (state_q == StFinish);
    busy     = (state_q != StIdle);
  end

  // Datapath next-state: operation sequencing and accumulator updates
  always_comb begin
    op_d       = op_q;
    xm_d       = xm_q;
    acc_d      = acc_q;
    m_d        = m_q;
    result_d   = result_q;
    scan_load  = 1'b0;
    scan_shift = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d     = in_r;
          op_d      = OpEnter;
          m_d       = in_m;
          scan_load = 1'b1;
        end
      end
      StWait: begin
        if (mm_done) begin
          unique case (op_q)
            OpEnter: begin
              xm_d = mm_result;
              op_d = (EW > 0) ? OpSquare : OpExit;
            end
            OpSquare: begin
              acc_d = mm_result;
              if (cur_bit) begin
                op_d = OpMultiply;
              end else begin
                scan_shift = 1'b1;
                op_d       = last_bit ? OpExit : OpSquare;
              end
            end
            OpMultiply: begin
              acc_d      = mm_result;
              scan_shift = 1'b1;
              op_d       = last_bit ? OpExit : OpSquare;
            end
            OpExit: result_d = mm_result;
            default: op_d = op_q;
          endcase
        end
      end
      default: ;
    endcase
  end

  // Operands are chosen from the post-update values so they can be registered
  // on the edge entering ISSUE and held steady through WAIT.
  always_comb begin
    sel_a = acc_d;
    sel_b = acc_d;
    unique case (op_d)
      OpEnter:    begin sel_a = in_x;  sel_b = in_r2;   end
      OpSquare:   begin sel_a = acc_d; sel_b = acc_d;   end
      OpMultiply: begin sel_a = acc_d; sel_b = xm_d;    end
      OpExit:     begin sel_a = acc_d; sel_b = DW'(1);  end
      default:    begin sel_a = acc_d; sel_b = acc_d;   end
    endcase
    mm_a_d = (state_d == StIssue) ? sel_a : mm_a_q;
    mm_b_d = (state_d == StIssue) ? sel_b : mm_b_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= OpEnter;
      xm_q     <= '0;
      acc_q    <= '0;
      m_q      <= '0;
      result_q <= '0;
      mm_a_q   <= '0;
      mm_b_q   <= '0;
    end else begin
      op_q     <= op_d;
      xm_q     <= xm_d;
      acc_q    <= acc_d;
      m_q      <= m_d;
      result_q <= result_d;
      mm_a_q   <= mm_a_d;
      mm_b_q   <= mm_b_d;
    end
  end

  assign result = result_q;
  assign mm_a   = mm_a_q;
  assign mm_b   = mm_b_q;
  assign mm_m   = m_q;

endmodule
